sine_phase_step: RTL
====================

SINE_PHASE_STEP -- requirements
Module: sine_phase_step

Interface
REQ-001 The block SHALL have parameter NR_CHANNELS, default 2, the number of sine channels served.
REQ-002 The block SHALL have parameter RADIAN_WIDTH, default 28, the output angle width in S2.(RADIAN_WIDTH-3) format.
REQ-003 The block SHALL have parameter FREQ_WIDTH, default 24, the frequency word width in U(FREQ_WIDTH-8).8 Hz format.
REQ-004 The block SHALL have parameter SAMPLE_RATE, default 48000, the sample rate in Hz.
REQ-005 clk  in  1  single clock; all logic SHALL be on its rising edge.
REQ-006 rst_n  in  1  reset, asynchronous and active-low.
REQ-007 s_freq_d  in  FREQ_WIDTH  channel frequency word.
REQ-008 s_freq_zero  in  1  requests a phase reset for the channel being written.
REQ-009 s_freq_ch  in  CHANNEL_WIDTH  channel being written; CHANNEL_WIDTH = clog2(NR_CHANNELS).
REQ-010 s_freq_dv  in  1  write valid.
REQ-011 s_freq_dr  out  1  write ready; the block SHALL hold it constantly 1 outside reset.
REQ-012 tick  in  1  one-cycle sample strobe.
REQ-013 m_sine_d  out  RADIAN_WIDTH  signed angle step.
REQ-014 m_sine_zero  out  1  phase-reset flag.
REQ-015 m_sine_ch  out  CHANNEL_WIDTH  output channel.
REQ-016 m_sine_dv / m_sine_dr  out / in  1 each  output valid / ready.

Function
REQ-017 Write handshake: the block SHALL take a write when s_freq_dv=1 and s_freq_ch<NR_CHANNELS, storing the word in freq[ch]; it SHALL ignore the write when s_freq_ch>=NR_CHANNELS.
REQ-018 A write with s_freq_zero=1 SHALL set zero_pend[ch].
REQ-019 FSM states SHALL be IDLE, CALC, SEND; on tick in IDLE the block SHALL set ch=0 and go to CALC.
REQ-020 CALC SHALL snapshot freq[ch], compute the step (REQ-023) and go to SEND, taking 1 cycle or the multiplier latency.
REQ-021 In SEND the block SHALL hold m_sine_dv=1 with stable data until m_sine_dv && m_sine_dr; it SHALL then go to IDLE if ch==NR_CHANNELS-1, else increment ch and go to CALC.
REQ-022 Latency SHALL be at most 3 cycles from tick to the first m_sine_dv for ch 0 when m_sine_dr=1.
REQ-023 step SHALL be (freq*STEP_K + 2^23) >> 24, where STEP_K = round(2*pi*2^(RADIAN_WIDTH+13)/SAMPLE_RATE); the product SHALL be full width and unsigned, and the result SHALL be positive.
REQ-024 Clamp: freq >= SAMPLE_RATE*128 (Nyquist) SHALL output exactly PI, where PI = 2*round(2^(RADIAN_WIDTH-3)*pi/2).
REQ-025 m_sine_zero SHALL equal zero_pend[ch] sampled at CALC.
REQ-026 zero_pend[ch] SHALL clear on the SEND handshake that carried m_sine_zero=1.
REQ-027 If a new zero write to the same channel coincides with that clear, set SHALL win.
REQ-028 A write to the channel currently in CALC/SEND SHALL take effect at the next tick.
REQ-029 A tick outside IDLE SHALL be dropped (overrun); the current sequence SHALL continue.

Reset
REQ-030 On rst_n=0 the block SHALL asynchronously set state=IDLE, ch=0, m_sine_dv=0, m_sine_d=0, m_sine_zero=0, m_sine_ch=0, all freq=0 and all zero_pend=0, and drive s_freq_dr=0 during reset.
REQ-031 Reset mid-SEND SHALL abandon the transfer, producing no further m_sine_dv until a tick after release.

Configuration
REQ-032 With macro SINE_PHASE_STEP_OVERRUN_EN defined, the block SHALL add output port overrun (1 bit), which sets on a dropped tick (REQ-029) and clears only on reset.
REQ-033 Without SINE_PHASE_STEP_OVERRUN_EN the port and its logic SHALL be absent; dropped ticks SHALL be silent.

Structure
REQ-034 The shared package sine_pkg SHALL hold the clog2 function, the MATH_PI constant and the PI / PI_OVER_2 derivation, which the sine generator shall also use.
REQ-035 The design SHALL use one sub-module, const_mult_rnd (constant multiply, round, shift), parameterised on width, constant and shift.

Verification
REQ-036 NR_CHANNELS=2, RADIAN_WIDTH=28, SAMPLE_RATE=48000: ch0 freq=256000 (1000 Hz), tick -> ch0 m_sine_d=4392264 (±1), m_sine_zero=0, followed by ch1 m_sine_d=0.
REQ-037 ch1 freq=6144000 (24000 Hz) or 0xFFFFFF -> m_sine_d=105414358 (PI) in both cases.
REQ-038 Write ch0 with s_freq_zero=1, then two ticks -> m_sine_zero=1 on the first ch0 output only; a re-write with zero in the same cycle as the clear -> zero=1 again on the next tick.
REQ-039 m_sine_dr held 0 for 10 cycles in SEND -> data stable, m_sine_dv=1 throughout; a tick during the hold is dropped and, with SINE_PHASE_STEP_OVERRUN_EN, overrun=1.
REQ-040 rst_n pulsed low mid-SEND -> m_sine_dv=0 immediately; after release with no tick, no output is produced.
REQ-041 A write to s_freq_ch=2 with NR_CHANNELS=2 -> ignored; both channels unchanged.

Source files
------------

// File: rtl/sine_pkg.sv
// Shared constants and constant-math helpers for the sine datapath
// (channel-index sizing, PI in radian fixed point, phase-step gain).
package sine_pkg;

    localparam real MATH_PI = 3.14159265358979323846;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        SEND = 2'd2
    } step_state_t;

    // Bits needed to hold the value n itself, so an index equal to the
    // channel count is representable and can be rejected as out of range.
    function automatic int clog2(input longint n);
        int r;
        r = 0;
        for (int i = 0; i < 63; i++) begin
            if ((n >> i) != 64'sd0) begin
                r = i + 1;
            end else begin
                r = r;
            end
        end
        return (r < 1) ? 1 : r;
    endfunction

    function automatic longint pi_over_2(input int rw);
        real x;
        x = (2.0 ** (rw - 3)) * MATH_PI / 2.0;
        return longint'(x);
    endfunction

    function automatic longint pi_q(input int rw);
        return 64'sd2 * pi_over_2(rw);
    endfunction

    // Gain mapping U.8 Hz to S2 radians per sample, pre-scaled by 2^24.
    function automatic longint step_k(input int rw, input int sr);
        real x;
        x = 2.0 * MATH_PI * (2.0 ** (rw + 13)) / real'(sr);
        return longint'(x);
    endfunction

endpackage

// File: rtl/const_mult_rnd.sv
// Unsigned multiply by a constant, add half an LSB, shift right.
module const_mult_rnd #(
    parameter int     IN_WIDTH  = 24,
    parameter int     OUT_WIDTH = 28,
    parameter int     K_WIDTH   = 29,
    parameter longint K         = 1,
    parameter int     SHIFT     = 24
) (
    input  logic [IN_WIDTH-1:0]  a,
    output logic [OUT_WIDTH-1:0] y
);

    localparam int P_WIDTH = IN_WIDTH + K_WIDTH + 1;
    localparam logic [P_WIDTH-1:0] K_P  = P_WIDTH'(K);
    localparam logic [P_WIDTH-1:0] HALF = P_WIDTH'(64'd1 << (SHIFT - 1));

    logic [P_WIDTH-1:0] prod_s;
    logic [P_WIDTH-1:0] sum_s;

    assign prod_s = P_WIDTH'(a) * K_P;
    assign sum_s  = prod_s + HALF;
    assign y      = OUT_WIDTH'(sum_s >> SHIFT);

endmodule

// File: rtl/sine_phase_step.sv
// Per-channel phase-step generator: on each sample tick, emits one angle
// step per channel. Optional sticky overrun output: SINE_PHASE_STEP_OVERRUN_EN.
module sine_phase_step
    import sine_pkg::*;
#(
    parameter int NR_CHANNELS  = 2,
    parameter int RADIAN_WIDTH = 28,
    parameter int FREQ_WIDTH   = 24,
    parameter int SAMPLE_RATE  = 48000,
    localparam int CHANNEL_WIDTH = clog2(NR_CHANNELS)
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [FREQ_WIDTH-1:0]    s_freq_d,
    input  logic                     s_freq_zero,
    input  logic [CHANNEL_WIDTH-1:0] s_freq_ch,
    input  logic                     s_freq_dv,
    output logic                     s_freq_dr,
    input  logic                     tick,
    output logic [RADIAN_WIDTH-1:0]  m_sine_d,
    output logic                     m_sine_zero,
    output logic [CHANNEL_WIDTH-1:0] m_sine_ch,
    output logic                     m_sine_dv,
    input  logic                     m_sine_dr
`ifdef SINE_PHASE_STEP_OVERRUN_EN
    ,
    output logic                     overrun
`endif
);

    localparam int     DEPTH   = 1 << CHANNEL_WIDTH;
    localparam longint STEP_K  = step_k(RADIAN_WIDTH, SAMPLE_RATE);
    localparam int     K_WIDTH = clog2(STEP_K);
    localparam logic [RADIAN_WIDTH-1:0]  PI_STEP  = RADIAN_WIDTH'(pi_q(RADIAN_WIDTH));
    localparam logic [FREQ_WIDTH:0]      NYQUIST  = (FREQ_WIDTH + 1)'(longint'(SAMPLE_RATE) * 64'sd128);
    localparam logic [CHANNEL_WIDTH-1:0] LAST_CH  = CHANNEL_WIDTH'(NR_CHANNELS - 1);
    localparam logic [CHANNEL_WIDTH-1:0] NR_CH_W  = CHANNEL_WIDTH'(NR_CHANNELS);

    step_state_t              state_r;
    logic [CHANNEL_WIDTH-1:0] ch_r;
    logic [FREQ_WIDTH-1:0]    freq_r [DEPTH];
    logic [DEPTH-1:0]         zero_pend_r;
    logic [DEPTH-1:0]         zero_pend_s;
    logic [DEPTH-1:0]         zero_set_s;
    logic [DEPTH-1:0]         zero_clr_s;
    logic [RADIAN_WIDTH-1:0]  m_d_r;
    logic                     m_zero_r;
    logic [CHANNEL_WIDTH-1:0] m_ch_r;
    logic                     m_dv_r;
    logic                     dr_r;
    logic                     wr_s;
    logic                     hs_s;
    logic [FREQ_WIDTH-1:0]    freq_sel_s;
    logic [RADIAN_WIDTH-1:0]  prod_step_s;
    logic [RADIAN_WIDTH-1:0]  step_s;

    assign wr_s       = s_freq_dv && (s_freq_ch < NR_CH_W);
    assign hs_s       = m_dv_r && m_sine_dr;
    assign freq_sel_s = freq_r[ch_r];

    assign s_freq_dr   = dr_r;
    assign m_sine_d    = m_d_r;
    assign m_sine_zero = m_zero_r;
    assign m_sine_ch   = m_ch_r;
    assign m_sine_dv   = m_dv_r;

    const_mult_rnd #(
        .IN_WIDTH  (FREQ_WIDTH),
        .OUT_WIDTH (RADIAN_WIDTH),
        .K_WIDTH   (K_WIDTH),
        .K         (STEP_K),
        .SHIFT     (24)
    ) u_mult (
        .a (freq_sel_s),
        .y (prod_step_s)
    );

    // Clamp at or above Nyquist to exactly PI.
    always_comb begin
        step_s = prod_step_s;
        if ({1'b0, freq_sel_s} >= NYQUIST) begin
            step_s = PI_STEP;
        end else begin
            step_s = prod_step_s;
        end
    end

    // Pending phase-reset flags; a new set wins over a simultaneous clear.
    always_comb begin
        zero_set_s = {DEPTH{1'b0}};
        zero_clr_s = {DEPTH{1'b0}};
        if (wr_s && s_freq_zero) begin
            zero_set_s[s_freq_ch] = 1'b1;
        end else begin
            zero_set_s = {DEPTH{1'b0}};
        end
        if (hs_s && m_zero_r) begin
            zero_clr_s[m_ch_r] = 1'b1;
        end else begin
            zero_clr_s = {DEPTH{1'b0}};
        end
        zero_pend_s = (zero_pend_r & ~zero_clr_s) | zero_set_s;
    end

    // Frequency table and pending-zero register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                freq_r[i] <= {FREQ_WIDTH{1'b0}};
            end
            zero_pend_r <= {DEPTH{1'b0}};
            dr_r        <= 1'b0;
        end else begin
            if (wr_s) begin
                freq_r[s_freq_ch] <= s_freq_d;
            end
            zero_pend_r <= zero_pend_s;
            dr_r        <= 1'b1;
        end
    end

    // Channel sequencer with registered output stage.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r  <= IDLE;
            ch_r     <= {CHANNEL_WIDTH{1'b0}};
            m_d_r    <= {RADIAN_WIDTH{1'b0}};
            m_zero_r <= 1'b0;
            m_ch_r   <= {CHANNEL_WIDTH{1'b0}};
            m_dv_r   <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (tick) begin
                        ch_r    <= {CHANNEL_WIDTH{1'b0}};
                        state_r <= CALC;
                    end
                end
                CALC: begin
                    m_d_r    <= step_s;
                    m_zero_r <= zero_pend_r[ch_r];
                    m_ch_r   <= ch_r;
                    m_dv_r   <= 1'b1;
                    state_r  <= SEND;
                end
                SEND: begin
                    if (hs_s) begin
                        m_dv_r <= 1'b0;
                        if (ch_r == LAST_CH) begin
                            state_r <= IDLE;
                        end else begin
                            ch_r    <= ch_r + {{(CHANNEL_WIDTH-1){1'b0}}, 1'b1};
                            state_r <= CALC;
                        end
                    end
                end
                default: begin
                    state_r <= IDLE;
                    m_dv_r  <= 1'b0;
                end
            endcase
        end
    end

`ifdef SINE_PHASE_STEP_OVERRUN_EN
    logic overrun_r;
    assign overrun = overrun_r;

    // Sticky flag for ticks that arrive while a sequence is still running.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            overrun_r <= 1'b0;
        end else if (tick && (state_r != IDLE)) begin
            overrun_r <= 1'b1;
        end
    end
`endif

endmodule
